// File: rtl/gfx_rom_arbiter_if.sv
// Bus bundle between the video fetch requesters, the ROM arbiter and the ROM/SDRAM bridge.
// slave: arbiter side; master: requesters plus ROM bridge side (used by the environment).
interface gfx_rom_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  localparam int unsigned NREQ = 4;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      data_out;
  logic               err;
  logic               rom_rd;
  logic [AW-1:0]      rom_addr;
  logic               rom_valid;
  logic [DW-1:0]      rom_data;

  modport slave (
    input  req, req_addr, rom_valid, rom_data,
    output ack, data_out, err, rom_rd, rom_addr
  );

  modport master (
    output req, req_addr, rom_valid, rom_data,
    input  ack, data_out, err, rom_rd, rom_addr
  );
endinterface

// File: rtl/gfx_rom_arbiter.sv
// Four-way round-robin arbiter sharing one graphics ROM read port, one read in flight, timeout abort.
// Optional: define SPRITE_PRIORITY_EN to let requester 3 (sprites) win whenever it requests.
module gfx_rom_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            n_reset,
  gfx_rom_arbiter_if.slave bus
);
  localparam int unsigned NREQ = 4;
  localparam int unsigned GW   = 2;
  localparam int unsigned TW   = 8;
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state, state_nx;
  logic [GW-1:0]   grant, grant_nx;
  logic [GW-1:0]   ptr, ptr_nx;
  logic            prio, prio_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [NREQ-1:0] ack_q, ack_nx;
  logic [DW-1:0]   data_q, data_nx;
  logic            err_q, err_nx;
  logic            rd_q, rd_nx;
  logic [AW-1:0]   addr_q, addr_nx;

  logic [GW-1:0]   cand;
  logic [GW-1:0]   rr_pick;
  logic            rr_found;
  logic [GW-1:0]   pick;
  logic            pick_prio;
  logic [AW-1:0]   pick_addr;
  logic            any_req;

  assign any_req = |bus.req;

  // Round-robin search starting one past the last grant, wrapping mod 4
  always_comb begin
    cand     = '0;
    rr_pick  = ptr;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + GW'(k);
      if (!rr_found && bus.req[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

`ifdef SPRITE_PRIORITY_EN
  // Sprites pre-empt the rotation; such a grant leaves the pointer alone
  always_comb begin
    pick      = rr_pick;
    pick_prio = 1'b0;
    if (bus.req[NREQ-1]) begin
      pick      = GW'(NREQ - 1);
      pick_prio = 1'b1;
    end
  end
`else
  always_comb begin
    pick      = rr_pick;
    pick_prio = 1'b0;
  end
`endif

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == GW'(i)) pick_addr = bus.req_addr[AW*i +: AW];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = ptr;
    prio_nx  = prio;
    timer_nx = timer;
    ack_nx   = '0;
    err_nx   = 1'b0;
    rd_nx    = 1'b0;
    data_nx  = data_q;
    addr_nx  = addr_q;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_nx = pick;
          prio_nx  = pick_prio;
          addr_nx  = pick_addr;
          rd_nx    = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // A return on the deadline cycle still counts as a good read
        if (bus.rom_valid) begin
          data_nx  = bus.rom_data;
          ack_nx   = NREQ'(1) << grant;
          state_nx = S_DONE;
        end else if (timer >= TIMEOUT_T) begin
          data_nx  = '1;
          err_nx   = 1'b1;
          ack_nx   = NREQ'(1) << grant;
          state_nx = S_DONE;
        end else if (timer != '1) begin
          timer_nx = timer + TW'(1);
        end
      end
      S_DONE: begin
        if (!prio) ptr_nx = grant;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= S_IDLE;
      grant  <= '0;
      ptr    <= GW'(NREQ - 1);
      prio   <= 1'b0;
      timer  <= '0;
      ack_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      ptr    <= ptr_nx;
      prio   <= prio_nx;
      timer  <= timer_nx;
      ack_q  <= ack_nx;
      data_q <= data_nx;
      err_q  <= err_nx;
      rd_q   <= rd_nx;
      addr_q <= addr_nx;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data_out = data_q;
  assign bus.err      = err_q;
  assign bus.rom_rd   = rd_q;
  assign bus.rom_addr = addr_q;
endmodule
